alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue side of the 8-bit ALU: accepts one 32-bit instruction per handshake and decodes it.
//  Reads operands from an internal 8x8 register file, drives ALU operands/select and waits a
//  fixed number of cycles. Then samples the ALU result and writes it back to the register file.
//  Sits between instruction fetch and the ALU; the ALU is a combinational responder to this block.
// PARAMETERS
//  ALU_WAIT  1  cycles operands are held before alu_result is sampled (legal 1..15)
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET_N      in   1   asynchronous, active-low reset
//  instr        in   32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm
//  instr_valid  in   1   instr is valid this cycle
//  instr_ready  out  1   block can accept instr this cycle
//  alu_data1    out  8   ALU operand 1
//  alu_data2    out  8   ALU operand 2
//  alu_select   out  3   ALU op: 000 fwd data2, 001 add, 010 and, 011 or
//  alu_result   in   8   ALU result
//  wb_en        out  1   one-cycle pulse: write-back committed
//  wb_addr      out  3   register written
//  wb_data      out  8   value written
//  illegal      out  1   one-cycle pulse: undefined opcode dropped
//  dbg_addr     in   3   debug register read address
//  dbg_data     out  8   combinational read of reg[dbg_addr]
// BEHAVIOUR
//  Reset (async, RESET_N=0): state IDLE, all 8 regs=0, alu_data1/alu_data2=0, alu_select=000.
//   Also wb_en/illegal=0, wb_addr/wb_data=0, wait counter=0. Reset mid-instruction aborts it
//   with no write. instr_ready=1 in the first cycle after release.
//  Register index = low 3 bits of each field; bits [7:3] ignored. Reg 0 is writable (not hardwired).
//  Decode (opcode -> data1, data2, select):
//   00 loadi  0,         imm,           000
//   01 mov    0,         reg[src2],     000
//   02 add    reg[src1], reg[src2],     001
//   03 sub    reg[src1], -reg[src2],    001 (two's complement, 8-bit wrap)
//   04 and    reg[src1], reg[src2],     010
//   05 or     reg[src1], reg[src2],     011
//   other opcodes are illegal.
//  All arithmetic is 8-bit and wraps; no carry or flag outputs.
//  FSM states:
//   IDLE:  instr_ready=1; accept on the edge where instr_valid & instr_ready.
//          On a legal opcode: register decoded operands/select onto the ALU ports and load
//          counter=ALU_WAIT-1, then go to EXEC.
//          On an illegal opcode: go to ERR; ALU ports unchanged.
//   EXEC:  instr_ready=0; ALU ports held stable; counter decrements each edge.
//          On the edge where counter==0: reg[dest]<=alu_result, wb_data<=alu_result,
//          wb_addr<=dest, wb_en<=1, then go to WB.
//   WB:    wb_en=1 for exactly this cycle; next edge go to IDLE and clear wb_en.
//   ERR:   illegal=1 for exactly this cycle; next edge go to IDLE and clear illegal.
//  Timing for an instruction accepted at edge k:
//   - regfile write at edge k+ALU_WAIT
//   - wb_en high during cycle k+ALU_WAIT..k+ALU_WAIT+1
//   - instr_ready returns after edge k+ALU_WAIT+1
//   - throughput is 1 instruction per ALU_WAIT+2 cycles
//  Operands are read at the accept edge and every prior write has already committed, so there
//   is no RAW hazard and no forwarding.
//  instr_valid while not ready: ignored. The source must hold instr until the handshake.
//  ALU ports keep their last values in IDLE, WB and ERR.
//  wb_addr/wb_data hold the last committed write until the next write.
//  dbg_data = reg[dbg_addr]; reflects a write from the edge after that write.
// TESTING
//  Reset, then loadi r1,5 / loadi r2,3 -> wb pulses (1,5),(2,3); dbg r1=5, r2=3.
//  With r1=5, r2=3: add r3,r1,r2 -> 8; sub r4,r1,r2 -> 2; sub r5,r2,r1 -> 0xFE;
//   and r6 -> 0x01; or r7 -> 0x07.
//  With r1=0xFF, r2=0x02: add -> 0x01 (wrap).
//  Timing, ALU_WAIT=1 then 3: accept at edge k -> alu_select stable k..k+W; wb_en exactly
//   1 cycle; instr_ready low for W+1 cycles.
//  Hold instr_valid=1 for back-to-back mov r0,r3 then add r0,r0,r0: second is accepted only
//   after the first wb_en, and reads updated r0 (8 -> 16).
//  Opcode 0x09 -> illegal pulse 1 cycle, no wb_en, registers unchanged.
//  Assert RESET_N low during EXEC -> no write, all regs 0, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue side of an 8-bit ALU: accepts one instruction per handshake, reads operands from an
// internal 8x8 register file, holds them on the ALU for ALU_WAIT cycles, then writes back.
module alu_issue_ctrl #(
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [7:0]  alu_data1,
    output logic [7:0]  alu_data2,
    output logic [2:0]  alu_select,
    input  logic [7:0]  alu_result,
    output logic        wb_en,
    output logic [2:0]  wb_addr,
    output logic [7:0]  wb_data,
    output logic        illegal,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    logic [1:0] state;
    logic [3:0] cnt;
    logic [2:0] dest_q;
    logic [7:0] regs [8];

    logic [7:0] opcode;
    logic [2:0] dest, src1, src2;
    logic [7:0] rd1, rd2;
    logic       dec_legal;
    logic [7:0] dec_d1, dec_d2;
    logic [2:0] dec_sel;
    logic       unused_fields;

    // Handshake: instr is consumed on a rising edge where instr_valid && instr_ready.
    // instr_ready depends only on state; the source holds instr stable until that edge.
    assign instr_ready = (state == IDLE);
    assign dbg_state   = state;
    assign dbg_data    = regs[dbg_addr];

    // Only the low 3 bits of each register field select a register.
    assign opcode        = instr[31:24];
    assign dest          = instr[18:16];
    assign src1          = instr[10:8];
    assign src2          = instr[2:0];
    assign unused_fields = ^{instr[23:19], instr[15:11]};
    assign rd1           = regs[src1];
    assign rd2           = regs[src2];

    always_comb begin
        dec_legal = 1'b1;
        dec_d1    = 8'd0;
        dec_d2    = 8'd0;
        dec_sel   = 3'b000;
        case (opcode)
            8'h00: dec_d2 = instr[7:0];
            8'h01: dec_d2 = rd2;
            8'h02: begin dec_d1 = rd1; dec_d2 = rd2;         dec_sel = 3'b001; end
            // Subtract is an add of the negated second operand.
            8'h03: begin dec_d1 = rd1; dec_d2 = 8'd0 - rd2;  dec_sel = 3'b001; end
            8'h04: begin dec_d1 = rd1; dec_d2 = rd2;         dec_sel = 3'b010; end
            8'h05: begin dec_d1 = rd1; dec_d2 = rd2;         dec_sel = 3'b011; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            dest_q     <= 3'd0;
            alu_data1  <= 8'd0;
            alu_data2  <= 8'd0;
            alu_select <= 3'b000;
            wb_en      <= 1'b0;
            wb_addr    <= 3'd0;
            wb_data    <= 8'd0;
            illegal    <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= 8'd0;
        end else begin
            wb_en   <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        if (dec_legal) begin
                            alu_data1  <= dec_d1;
                            alu_data2  <= dec_d2;
                            alu_select <= dec_sel;
                            dest_q     <= dest;
                            cnt        <= 4'(ALU_WAIT - 1);
                            state      <= EXEC;
                        end else begin
                            illegal <= 1'b1;
                            state   <= ERR;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        regs[dest_q] <= alu_result;
                        wb_addr      <= dest_q;
                        wb_data      <= alu_result;
                        wb_en        <= 1'b1;
                        state        <= WB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WB:      state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_WAIT=1 and 3) driven by directed and random
// instructions, checked against a register-file model and a write-back expected queue.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr       [2];
    logic        instr_valid [2];
    logic        instr_ready [2];
    logic [7:0]  alu_data1   [2];
    logic [7:0]  alu_data2   [2];
    logic [2:0]  alu_select  [2];
    logic [7:0]  alu_result  [2];
    logic        wb_en       [2];
    logic [2:0]  wb_addr     [2];
    logic [7:0]  wb_data     [2];
    logic        illegal     [2];
    logic [2:0]  dbg_addr    [2];
    logic [7:0]  dbg_data    [2];
    logic [1:0]  dbg_state   [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ref_regs [2][8];
    logic [7:0]  last_d1  [2];
    logic [7:0]  last_d2  [2];
    logic [2:0]  last_sel [2];
    logic [10:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_WAIT(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .instr(instr[0]), .instr_valid(instr_valid[0]),
        .instr_ready(instr_ready[0]), .alu_data1(alu_data1[0]), .alu_data2(alu_data2[0]),
        .alu_select(alu_select[0]), .alu_result(alu_result[0]), .wb_en(wb_en[0]),
        .wb_addr(wb_addr[0]), .wb_data(wb_data[0]), .illegal(illegal[0]),
        .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0]), .dbg_state(dbg_state[0])
    );

    alu_issue_ctrl #(.ALU_WAIT(3)) dut_w3 (
        .clk(clk), .rst_n(rst_n), .instr(instr[1]), .instr_valid(instr_valid[1]),
        .instr_ready(instr_ready[1]), .alu_data1(alu_data1[1]), .alu_data2(alu_data2[1]),
        .alu_select(alu_select[1]), .alu_result(alu_result[1]), .wb_en(wb_en[1]),
        .wb_addr(wb_addr[1]), .wb_data(wb_data[1]), .illegal(illegal[1]),
        .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1]), .dbg_state(dbg_state[1])
    );

    // Combinational ALU responder.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            case (alu_select[i])
                3'b000:  alu_result[i] = alu_data2[i];
                3'b001:  alu_result[i] = alu_data1[i] + alu_data2[i];
                3'b010:  alu_result[i] = alu_data1[i] & alu_data2[i];
                3'b011:  alu_result[i] = alu_data1[i] | alu_data2[i];
                default: alu_result[i] = 8'h00;
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] d,
                                       input logic [7:0] s1, input logic [7:0] s2);
        return {op, d, s1, s2};
    endfunction

    function automatic void model(input int idx, input logic [31:0] ins, output logic legal,
                                  output logic [2:0] sel, output logic [7:0] d1,
                                  output logic [7:0] d2, output logic [7:0] res,
                                  output logic [2:0] dst);
        logic [7:0] a, b;
        a     = ref_regs[idx][ins[10:8]];
        b     = ref_regs[idx][ins[2:0]];
        dst   = ins[18:16];
        legal = 1'b1;
        sel   = 3'b000;
        d1    = 8'd0;
        d2    = 8'd0;
        res   = 8'd0;
        case (ins[31:24])
            8'h00: begin d2 = ins[7:0]; res = ins[7:0]; end
            8'h01: begin d2 = b; res = b; end
            8'h02: begin sel = 3'b001; d1 = a; d2 = b;        res = a + b; end
            8'h03: begin sel = 3'b001; d1 = a; d2 = 8'd0 - b; res = a - b; end
            8'h04: begin sel = 3'b010; d1 = a; d2 = b;        res = a & b; end
            8'h05: begin sel = 3'b011; d1 = a; d2 = b;        res = a | b; end
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 8; r++) ref_regs[i][r] = 8'd0;
            last_d1[i]  = 8'd0;
            last_d2[i]  = 8'd0;
            last_sel[i] = 3'b000;
        end
        exp_q.delete();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_accept(input int idx, input logic [31:0] ins);
        int c;
        instr[idx]       = ins;
        instr_valid[idx] = 1'b1;
        c = 0;
        while (instr_ready[idx] !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (instr_ready[idx] !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake dut%0d: instr_ready=%b after %0d cycles, required 1", idx, instr_ready[idx], c);
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid[idx] = 1'b0;
    endtask

    task automatic run_instr(input int idx, input logic [31:0] ins);
        logic        legal;
        logic [2:0]  sel, dst;
        logic [7:0]  d1, d2, res;
        logic [10:0] exp_wb;
        int          w, c;
        w = (idx == 0) ? 1 : 3;
        model(idx, ins, legal, sel, d1, d2, res, dst);
        drive_accept(idx, ins);
        if (legal) begin
            exp_q.push_back({dst, res});
            c = 0;
            while (wb_en[idx] !== 1'b1 && c < w + 4) begin
                n_tests++;
                if (instr_ready[idx] !== 1'b0 ||
                    {alu_select[idx], alu_data1[idx], alu_data2[idx]} !== {sel, d1, d2}) begin
                    n_fail++;
                    $display("FAIL exec_ports dut%0d c%0d instr=%h: ready=%b sel/d1/d2=%h, required ready=0 %h",
                             idx, c, ins, instr_ready[idx], {alu_select[idx], alu_data1[idx], alu_data2[idx]}, {sel, d1, d2});
                end
                c++;
                @(negedge clk);
            end
            n_tests++;
            if (c != w) begin
                n_fail++;
                $display("FAIL wb_latency dut%0d instr=%h: %0d cycles, required %0d", idx, ins, c, w);
            end
            exp_wb = exp_q.pop_front();
            n_tests++;
            if ({wb_en[idx], instr_ready[idx], wb_addr[idx], wb_data[idx]} !== {2'b10, exp_wb} ||
                {alu_select[idx], alu_data1[idx], alu_data2[idx]} !== {sel, d1, d2}) begin
                n_fail++;
                $display("FAIL wb_value dut%0d instr=%h: en/rdy/addr/data=%b%b %h %h ports=%h, required 10 %h %h ports=%h",
                         idx, ins, wb_en[idx], instr_ready[idx], wb_addr[idx], wb_data[idx],
                         {alu_select[idx], alu_data1[idx], alu_data2[idx]}, exp_wb[10:8], exp_wb[7:0], {sel, d1, d2});
            end
            @(negedge clk);
            n_tests++;
            if ({wb_en[idx], instr_ready[idx], wb_addr[idx], wb_data[idx]} !== {2'b01, exp_wb}) begin
                n_fail++;
                $display("FAIL wb_pulse_end dut%0d: en=%b rdy=%b addr=%h data=%h, required en=0 rdy=1 %h %h",
                         idx, wb_en[idx], instr_ready[idx], wb_addr[idx], wb_data[idx], exp_wb[10:8], exp_wb[7:0]);
            end
            ref_regs[idx][dst] = res;
            last_sel[idx] = sel;
            last_d1[idx]  = d1;
            last_d2[idx]  = d2;
            dbg_addr[idx] = dst;
            #1;
            n_tests++;
            if (dbg_data[idx] !== res) begin
                n_fail++;
                $display("FAIL dbg_after_wb dut%0d r%0d: %h, required %h", idx, dst, dbg_data[idx], res);
            end
        end else begin
            n_tests++;
            if ({illegal[idx], wb_en[idx]} !== 2'b10 ||
                {alu_select[idx], alu_data1[idx], alu_data2[idx]} !== {last_sel[idx], last_d1[idx], last_d2[idx]}) begin
                n_fail++;
                $display("FAIL illegal_pulse dut%0d op=%h: ill/wb=%b%b ports=%h, required 10 ports=%h", idx, ins[31:24],
                         illegal[idx], wb_en[idx], {alu_select[idx], alu_data1[idx], alu_data2[idx]},
                         {last_sel[idx], last_d1[idx], last_d2[idx]});
            end
            @(negedge clk);
            n_tests++;
            if ({illegal[idx], wb_en[idx], instr_ready[idx]} !== 3'b001) begin
                n_fail++;
                $display("FAIL illegal_end dut%0d: ill/wb/rdy=%b%b%b, required 001", idx, illegal[idx], wb_en[idx], instr_ready[idx]);
            end
            for (int r = 0; r < 8; r++) begin
                dbg_addr[idx] = 3'(r);
                #1;
                n_tests++;
                if (dbg_data[idx] !== ref_regs[idx][r]) begin
                    n_fail++;
                    $display("FAIL illegal_regs dut%0d r%0d: %h, required %h", idx, r, dbg_data[idx], ref_regs[idx][r]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            instr[i] = 32'd0;
            instr_valid[i] = 1'b0;
            dbg_addr[i] = 3'd0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({instr_ready[i], wb_en[i], illegal[i], wb_addr[i], wb_data[i], alu_select[i], alu_data1[i], alu_data2[i]}
                !== {3'b100, 3'd0, 8'd0, 3'd0, 8'd0, 8'd0}) begin
                n_fail++;
                $display("FAIL reset_outputs dut%0d: rdy/wb/ill=%b%b%b addr=%h data=%h sel=%h d1=%h d2=%h, required 100 and zeros",
                         i, instr_ready[i], wb_en[i], illegal[i], wb_addr[i], wb_data[i], alu_select[i], alu_data1[i], alu_data2[i]);
            end
            for (int r = 0; r < 8; r++) begin
                dbg_addr[i] = 3'(r);
                #1;
                n_tests++;
                if (dbg_data[i] !== 8'd0) begin
                    n_fail++;
                    $display("FAIL reset_regs dut%0d r%0d: %h, required 00", i, r, dbg_data[i]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_loadi();
        run_instr(0, mk(8'h00, 8'h01, 8'h00, 8'h05));
        run_instr(0, mk(8'h00, 8'h02, 8'h00, 8'h03));
    endtask

    task automatic test_alu_ops();
        logic [7:0] want [5];
        want = '{8'h08, 8'h02, 8'hFE, 8'h01, 8'h07};
        run_instr(0, mk(8'h02, 8'h03, 8'h01, 8'h02));
        run_instr(0, mk(8'h03, 8'h04, 8'h01, 8'h02));
        run_instr(0, mk(8'h03, 8'h05, 8'h02, 8'h01));
        run_instr(0, mk(8'h04, 8'h06, 8'h01, 8'h02));
        run_instr(0, mk(8'h05, 8'h07, 8'h01, 8'h02));
        for (int r = 3; r < 8; r++) begin
            dbg_addr[0] = 3'(r);
            #1;
            n_tests++;
            if (dbg_data[0] !== want[r-3]) begin
                n_fail++;
                $display("FAIL alu_ops_const r%0d: %h, required %h", r, dbg_data[0], want[r-3]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] i1, i2;
        logic        l;
        logic [2:0]  s, dst1, dst2;
        logic [7:0]  a, b, r1, r2;
        logic [10:0] e;
        int          c, c_wb;
        i1 = mk(8'h01, 8'h00, 8'h00, 8'h03);
        i2 = mk(8'h02, 8'h00, 8'h00, 8'h00);
        model(0, i1, l, s, a, b, r1, dst1);
        ref_regs[0][dst1] = r1;
        model(0, i2, l, s, a, b, r2, dst2);
        exp_q.push_back({dst1, r1});
        exp_q.push_back({dst2, r2});
        last_sel[0] = s; last_d1[0] = a; last_d2[0] = b;
        instr[0] = i1;
        instr_valid[0] = 1'b1;
        c = 0;
        while (instr_ready[0] !== 1'b1 && c < 20) begin @(negedge clk); c++; end
        @(posedge clk);
        @(negedge clk);
        instr[0] = i2;
        c = 0;
        c_wb = -1;
        while (instr_ready[0] !== 1'b1 && c < 10) begin
            if (wb_en[0] === 1'b1 && c_wb < 0) begin
                c_wb = c;
                e = exp_q.pop_front();
                n_tests++;
                if ({wb_addr[0], wb_data[0]} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_first_wb: addr=%h data=%h, required %h %h", wb_addr[0], wb_data[0], e[10:8], e[7:0]);
                end
            end
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (c_wb < 0 || c <= c_wb || instr_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_order: wb at %0d, ready at %0d, required wb before ready", c_wb, c);
        end
        @(posedge clk);
        @(negedge clk);
        instr_valid[0] = 1'b0;
        c = 0;
        while (wb_en[0] !== 1'b1 && c < 10) begin @(negedge clk); c++; end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
        n_tests++;
        if ({wb_en[0], wb_addr[0], wb_data[0]} !== {1'b1, e}) begin
            n_fail++;
            $display("FAIL b2b_second_wb: en=%b addr=%h data=%h, required 1 %h %h", wb_en[0], wb_addr[0], wb_data[0], e[10:8], e[7:0]);
        end
        ref_regs[0][dst2] = r2;
        @(negedge clk);
        dbg_addr[0] = 3'd0;
        #1;
        n_tests++;
        if (dbg_data[0] !== 8'd16) begin
            n_fail++;
            $display("FAIL b2b_r0: %h, required 10", dbg_data[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        run_instr(0, mk(8'h00, 8'h01, 8'h00, 8'hFF));
        run_instr(0, mk(8'h00, 8'h02, 8'h00, 8'h02));
        run_instr(0, mk(8'h02, 8'h06, 8'h01, 8'h02));
        n_tests++;
        if (dbg_data[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_add: %h, required 01", dbg_data[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_timing_w3();
        run_instr(1, mk(8'h00, 8'h01, 8'h00, 8'h05));
        run_instr(1, mk(8'h00, 8'h02, 8'h00, 8'h03));
        run_instr(1, mk(8'h03, 8'h05, 8'h02, 8'h01));
    endtask

    task automatic test_illegal();
        run_instr(0, mk(8'h09, 8'h01, 8'h01, 8'h02));
        run_instr(1, mk(8'h09, 8'h02, 8'h01, 8'h02));
        run_instr(0, mk(8'hFF, 8'h03, 8'h03, 8'h03));
    endtask

    task automatic test_random();
        logic [7:0] op;
        int         k;
        for (int n = 0; n < 50; n++) begin
            k = $urandom_range(0, 9);
            if (k <= 5)      op = 8'(k);
            else if (k == 6) op = 8'h09;
            else             op = 8'($urandom_range(6, 255));
            run_instr((n % 4 == 3) ? 1 : 0,
                      mk(op, 8'($urandom), 8'($urandom), 8'($urandom)));
        end
    endtask

    task automatic test_reset_mid_exec();
        drive_accept(1, mk(8'h00, 8'h05, 8'h00, 8'h77));
        n_tests++;
        if ({instr_ready[1], wb_en[1]} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_exec_state: rdy/wb=%b%b, required 00", instr_ready[1], wb_en[1]);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({wb_en[1], instr_ready[1]} !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_exec_async: wb/rdy=%b%b, required 01", wb_en[1], instr_ready[1]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if ({wb_en[1], instr_ready[1], wb_addr[1], wb_data[1]} !== {2'b01, 3'd0, 8'd0}) begin
                n_fail++;
                $display("FAIL mid_exec_after c%0d: wb/rdy=%b%b addr=%h data=%h, required 01 0 00",
                         c, wb_en[1], instr_ready[1], wb_addr[1], wb_data[1]);
            end
        end
        for (int r = 0; r < 8; r++) begin
            dbg_addr[1] = 3'(r);
            #1;
            n_tests++;
            if (dbg_data[1] !== 8'd0) begin
                n_fail++;
                $display("FAIL mid_exec_regs r%0d: %h, required 00", r, dbg_data[1]);
            end
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        apply_reset();
        test_reset();
        test_loadi();
        test_alu_ops();
        test_back_to_back();
        test_wrap();
        test_timing_w3();
        test_illegal();
        test_random();
        test_reset_mid_exec();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL exp_q_drained: %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
